// File: rtl/pv1000_vram_arbiter.sv
`timescale 1ns/1ps
// Shares the single external RAM/VRAM port between the Z80 bus and the video fetcher.
// Video has priority; a streak limiter bounds how long a waiting CPU can be starved.
module pv1000_vram_arbiter #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned VID_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_a,
    output logic [7:0]        vid_q,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_ce_n,
    output logic              mem_we_n,
    output logic [7:0]        mem_d,
    input  logic [7:0]        mem_di
);
    localparam logic [3:0]        BURST_MAX = 4'(VID_BURST_MAX);
    localparam logic [ADDR_W-1:0] RAM_BASE  = ADDR_W'(32'h8000);

    logic              cpu_busy;
    logic              vid_busy;
    logic [3:0]        vid_streak;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_cpu;
    logic [RD_LAT-1:0] tag_we;

    logic cpu_elig;
    logic vid_elig;
    logic grant_cpu;
    logic grant_vid;
    logic grant_any;
    logic ret_v;
    logic ret_cpu;
    logic ret_we;

    always_comb begin
        // An ack/valid cycle still sees the old request held high, so it must not re-grant.
        cpu_elig  = cpu_req & ~cpu_busy & ~cpu_ack;
        vid_elig  = vid_req & ~vid_busy & ~vid_valid;
        grant_vid = vid_elig & ~(cpu_elig & (vid_streak == BURST_MAX));
        grant_cpu = cpu_elig & ~grant_vid;
        grant_any = grant_cpu | grant_vid;
        ret_v     = tag_v[RD_LAT-1];
        ret_cpu   = tag_cpu[RD_LAT-1];
        ret_we    = tag_we[RD_LAT-1];
    end

    assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_a      <= '0;
            mem_d      <= '0;
            mem_ce_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            cpu_q      <= '0;
            vid_q      <= '0;
            cpu_ack    <= 1'b0;
            vid_valid  <= 1'b0;
            cpu_busy   <= 1'b0;
            vid_busy   <= 1'b0;
            vid_streak <= '0;
            tag_v      <= '0;
            tag_cpu    <= '0;
            tag_we     <= '0;
        end else begin
            // Tag pipeline: new tag enters bit 0, the oldest retires from bit RD_LAT-1.
            tag_v    <= RD_LAT'({tag_v, grant_any});
            tag_cpu  <= RD_LAT'({tag_cpu, grant_cpu});
            tag_we   <= RD_LAT'({tag_we, grant_cpu & cpu_we});

            mem_ce_n <= ~grant_any;
            mem_we_n <= ~(grant_cpu & cpu_we & (cpu_a >= RAM_BASE));
            if (grant_cpu) begin
                mem_a <= cpu_a;
                if (cpu_we) mem_d <= cpu_d;
            end else if (grant_vid) begin
                mem_a <= vid_a;
            end

            cpu_ack   <= ret_v & ret_cpu;
            vid_valid <= ret_v & ~ret_cpu;
            if (ret_v & ret_cpu & ~ret_we) cpu_q <= mem_di;
            if (ret_v & ~ret_cpu) vid_q <= mem_di;

            if (grant_cpu) cpu_busy <= 1'b1;
            else if (ret_v & ret_cpu) cpu_busy <= 1'b0;
            if (grant_vid) vid_busy <= 1'b1;
            else if (ret_v & ~ret_cpu) vid_busy <= 1'b0;

            if (!cpu_elig || grant_cpu) vid_streak <= '0;
            else if (grant_vid && vid_streak != BURST_MAX) vid_streak <= vid_streak + 4'd1;
        end
    end
endmodule
